wb_stage: RTL and testbench

Pipelined, parametrised write-back stage for the pipelined processor core. It takes one retiring instruction per cycle from the memory stage and selects the integer and FP write-back values: JAL link, ALU/FPU result, memory load data, or cross-file move. It drives registered write strobes into the integer and FP register files. Loads with variable memory latency are handled by a small FSM that stalls the upstream stage until read data returns.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_src_mux.sv | 55 +++++
 rtl/wb_stage.sv | 218 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
//==============================================================================
// Module      : wb_pkg
// Description : Shared definitions for the write-back stage: FSM state
//               encoding and default datapath widths.
// Revision    : 1.0 - initial release
//==============================================================================
package wb_pkg;

    // Default widths of the integer/FP register-file datapath.
    localparam int WB_DATA_W_DEFAULT  = 32;
    localparam int WB_RADDR_W_DEFAULT = 5;

    // Write-back FSM: IDLE accepts instructions, WAIT_MEM stalls upstream
    // until load data returns.
    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_src_mux.sv
`default_nettype none
//==============================================================================
// Module      : wb_src_mux
// Description : Combinational priority select of the next integer and FP
//               write-back values. Shared by the immediate-retire path and
//               the load-return path of wb_stage.
// Ports       : i_busWCtrl/i_movInstr/i_memToReg - source selects
//               i_jalOut/i_aluOut/i_fbusA         - integer candidates
//               i_busA/i_fpuOut                   - FP candidates
//               i_loadData                        - memory load data
//               o_busWNext/o_fbusWNext            - selected values
// Revision    : 1.0 - initial release
//==============================================================================
module wb_src_mux
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W_DEFAULT
) (
    input  logic              i_busWCtrl,
    input  logic              i_movInstr,
    input  logic              i_memToReg,
    input  logic [DATA_W-1:0] i_jalOut,
    input  logic [DATA_W-1:0] i_aluOut,
    input  logic [DATA_W-1:0] i_fpuOut,
    input  logic [DATA_W-1:0] i_busA,
    input  logic [DATA_W-1:0] i_fbusA,
    input  logic [DATA_W-1:0] i_loadData,
    output logic [DATA_W-1:0] o_busWNext,
    output logic [DATA_W-1:0] o_fbusWNext
);

    // Integer: JAL link > cross-file move > load > ALU.
    always_comb begin
        o_busWNext = i_aluOut;
        if (i_busWCtrl) begin
            o_busWNext = i_jalOut;
        end else if (i_movInstr) begin
            o_busWNext = i_fbusA;
        end else if (i_memToReg) begin
            o_busWNext = i_loadData;
        end
    end

    // FP: cross-file move > load > FPU.
    always_comb begin
        o_fbusWNext = i_fpuOut;
        if (i_movInstr) begin
            o_fbusWNext = i_busA;
        end else if (i_memToReg) begin
            o_fbusWNext = i_loadData;
        end
    end

endmodule : wb_src_mux
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
//==============================================================================
// Module      : wb_stage
// Description : Pipelined write-back stage. Selects integer/FP write-back
//               data, drives registered one-cycle write strobes and stalls
//               upstream while a variable-latency load is outstanding.
// Ports       : clk, reset (async, active-high)
//               in_valid/in_ready  - upstream handshake
//               flush              - squash pending load
//               alu_out, fpu_out, busA, fbusA, jal_out - data sources
//               mem_to_reg, mov_instr, busW_ctrl       - source selects
//               reg_wr, freg_wr, rd, frd               - destinations
//               mem_rdata, mem_rvalid                  - load return
//               busW, fbusW, rw, frw, reg_we, freg_we  - register-file writes
// Options     : WB_PENDING_EN adds pend_valid/pend_rd/pend_frd/pend_is_f
//               for the hazard unit.
// Revision    : 1.0 - initial release
//==============================================================================
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W_DEFAULT,
    parameter int RADDR_W = WB_RADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [DATA_W-1:0]  fpu_out,
    input  logic [DATA_W-1:0]  busA,
    input  logic [DATA_W-1:0]  fbusA,
    input  logic [DATA_W-1:0]  jal_out,
    input  logic               mem_to_reg,
    input  logic               mov_instr,
    input  logic               busW_ctrl,
    input  logic               reg_wr,
    input  logic               freg_wr,
    input  logic [RADDR_W-1:0] rd,
    input  logic [RADDR_W-1:0] frd,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_rvalid,
    output logic [DATA_W-1:0]  busW,
    output logic [DATA_W-1:0]  fbusW,
    output logic [RADDR_W-1:0] rw,
    output logic [RADDR_W-1:0] frw,
    output logic               reg_we,
    output logic               freg_we
`ifdef WB_PENDING_EN
    ,
    output logic               pend_valid,
    output logic [RADDR_W-1:0] pend_rd,
    output logic [RADDR_W-1:0] pend_frd,
    output logic               pend_is_f
`endif
);

    wb_state_e          r_state;
    wb_state_e          w_nextState;

    // Fields captured from an accepted load-wait instruction.
    logic               r_lBusWCtrl;
    logic               r_lRegWr;
    logic               r_lFregWr;
    logic [RADDR_W-1:0] r_lRd;
    logic [RADDR_W-1:0] r_lFrd;
    logic [DATA_W-1:0]  r_lJalOut;

    logic [DATA_W-1:0]  r_busW;
    logic [DATA_W-1:0]  r_fbusW;
    logic [RADDR_W-1:0] r_rw;
    logic [RADDR_W-1:0] r_frw;
    logic               r_regWe;
    logic               r_fregWe;

    logic               w_waiting;
    logic               w_accept;
    logic               w_loadWait;
    logic               w_latch;
    logic               w_retire;
    logic               w_retRegWr;
    logic               w_retFregWr;
    logic [RADDR_W-1:0] w_retRd;
    logic [RADDR_W-1:0] w_retFrd;
    logic [DATA_W-1:0]  w_busWNext;
    logic [DATA_W-1:0]  w_fbusWNext;

    assign w_waiting  = (r_state == WB_WAIT_MEM);
    assign in_ready   = !w_waiting;
    assign w_accept   = in_valid && in_ready;
    assign w_loadWait = mem_to_reg && !mov_instr;

    // A load-wait is never a move, so on the return path the move select is
    // forced low and the live busA/fbusA inputs are don't-care.
    wb_src_mux #(
        .DATA_W (DATA_W)
    ) u_srcMux (
        .i_busWCtrl  (w_waiting ? r_lBusWCtrl : busW_ctrl),
        .i_movInstr  (w_waiting ? 1'b0        : mov_instr),
        .i_memToReg  (w_waiting ? 1'b1        : mem_to_reg),
        .i_jalOut    (w_waiting ? r_lJalOut   : jal_out),
        .i_aluOut    (alu_out),
        .i_fpuOut    (fpu_out),
        .i_busA      (busA),
        .i_fbusA     (fbusA),
        .i_loadData  (mem_rdata),
        .o_busWNext  (w_busWNext),
        .o_fbusWNext (w_fbusWNext)
    );

    // Next-state and retirement decode.
    always_comb begin
        w_nextState = r_state;
        w_latch     = 1'b0;
        w_retire    = 1'b0;
        w_retRegWr  = reg_wr;
        w_retFregWr = freg_wr;
        w_retRd     = rd;
        w_retFrd    = frd;
        case (r_state)
            WB_IDLE: begin
                // flush has no meaning here; acceptance proceeds normally.
                if (w_accept) begin
                    if (w_loadWait) begin
                        w_latch     = 1'b1;
                        w_nextState = WB_WAIT_MEM;
                    end else begin
                        w_retire = 1'b1;
                    end
                end
            end
            WB_WAIT_MEM: begin
                w_retRegWr  = r_lRegWr;
                w_retFregWr = r_lFregWr;
                w_retRd     = r_lRd;
                w_retFrd    = r_lFrd;
                // flush beats a simultaneous data return.
                if (flush) begin
                    w_nextState = WB_IDLE;
                end else if (mem_rvalid) begin
                    w_retire    = 1'b1;
                    w_nextState = WB_IDLE;
                end
            end
            default: begin
                w_nextState = WB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Load-wait capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lBusWCtrl <= 1'b0;
            r_lRegWr    <= 1'b0;
            r_lFregWr   <= 1'b0;
            r_lRd       <= '0;
            r_lFrd      <= '0;
            r_lJalOut   <= '0;
        end else if (w_latch) begin
            r_lBusWCtrl <= busW_ctrl;
            r_lRegWr    <= reg_wr;
            r_lFregWr   <= freg_wr;
            r_lRd       <= rd;
            r_lFrd      <= frd;
            r_lJalOut   <= jal_out;
        end
    end

    // Write-port registers. Strobes last one cycle; data/address are only
    // updated for the file actually being written so they hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busW   <= '0;
            r_fbusW  <= '0;
            r_rw     <= '0;
            r_frw    <= '0;
            r_regWe  <= 1'b0;
            r_fregWe <= 1'b0;
        end else begin
            r_regWe  <= w_retire && w_retRegWr;
            r_fregWe <= w_retire && w_retFregWr;
            if (w_retire && w_retRegWr) begin
                r_busW <= w_busWNext;
                r_rw   <= w_retRd;
            end
            if (w_retire && w_retFregWr) begin
                r_fbusW <= w_fbusWNext;
                r_frw   <= w_retFrd;
            end
        end
    end

    assign busW    = r_busW;
    assign fbusW   = r_fbusW;
    assign rw      = r_rw;
    assign frw     = r_frw;
    assign reg_we  = r_regWe;
    assign freg_we = r_fregWe;

`ifdef WB_PENDING_EN
    assign pend_valid = w_waiting;
    assign pend_rd    = r_lRd;
    assign pend_frd   = r_lFrd;
    assign pend_is_f  = r_lFregWr;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
//==============================================================================
// Module      : tb_wb_stage
// Description : Self-checking directed bench for wb_stage with a retirement
//               scoreboard. Pending-load outputs are checked when
//               WB_PENDING_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    typedef struct {
        logic          regWe;
        logic          fregWe;
        logic [DW-1:0] busW;
        logic [DW-1:0] fbusW;
        logic [AW-1:0] rw;
        logic [AW-1:0] frw;
    } ret_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready, flush;
    logic [DW-1:0] alu_out, fpu_out, busA, fbusA, jal_out, mem_rdata;
    logic          mem_to_reg, mov_instr, busW_ctrl, reg_wr, freg_wr, mem_rvalid;
    logic [AW-1:0] rd, frd;
    logic [DW-1:0] busW, fbusW;
    logic [AW-1:0] rw, frw;
    logic          reg_we, freg_we;
`ifdef WB_PENDING_EN
    logic          pend_valid, pend_is_f;
    logic [AW-1:0] pend_rd, pend_frd;
`endif

    int   checks   = 0;
    int   failures = 0;
    ret_t sbQ[$];

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DW), .RADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .alu_out    (alu_out),
        .fpu_out    (fpu_out),
        .busA       (busA),
        .fbusA      (fbusA),
        .jal_out    (jal_out),
        .mem_to_reg (mem_to_reg),
        .mov_instr  (mov_instr),
        .busW_ctrl  (busW_ctrl),
        .reg_wr     (reg_wr),
        .freg_wr    (freg_wr),
        .rd         (rd),
        .frd        (frd),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .busW       (busW),
        .fbusW      (fbusW),
        .rw         (rw),
        .frw        (frw),
        .reg_we     (reg_we),
        .freg_we    (freg_we)
`ifdef WB_PENDING_EN
        ,
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd),
        .pend_frd   (pend_frd),
        .pend_is_f  (pend_is_f)
`endif
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rWe, input logic fWe, input logic [DW-1:0] bw,
                        input logic [DW-1:0] fbw, input logic [AW-1:0] a, input logic [AW-1:0] fa);
        ret_t e;
        e.regWe = rWe; e.fregWe = fWe; e.busW = bw; e.fbusW = fbw; e.rw = a; e.frw = fa;
        sbQ.push_back(e);
    endtask

    // Compare any retirement visible this cycle against the scoreboard head.
    task automatic sbCheck();
        ret_t e;
        if (reg_we || freg_we) begin
            if (sbQ.size() == 0) begin
                chk("spurious_strobe", {30'd0, reg_we, freg_we}, '0);
            end else begin
                e = sbQ.pop_front();
                chk("sb_reg_we", {31'd0, reg_we}, {31'd0, e.regWe});
                chk("sb_freg_we", {31'd0, freg_we}, {31'd0, e.fregWe});
                if (e.regWe) begin
                    chk("sb_busW", busW, e.busW);
                    chk("sb_rw", {27'd0, rw}, {27'd0, e.rw});
                end
                if (e.fregWe) begin
                    chk("sb_fbusW", fbusW, e.fbusW);
                    chk("sb_frw", {27'd0, frw}, {27'd0, e.frw});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        sbCheck();
    endtask

    task automatic clearIn();
        in_valid = 0; flush = 0; mem_to_reg = 0; mov_instr = 0; busW_ctrl = 0;
        reg_wr = 0; freg_wr = 0; mem_rvalid = 0;
        alu_out = '0; fpu_out = '0; busA = '0; fbusA = '0; jal_out = '0; mem_rdata = '0;
        rd = '0; frd = '0;
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, "_busW"}, busW, '0);
        chk({tag, "_fbusW"}, fbusW, '0);
        chk({tag, "_rw_frw"}, {22'd0, rw, frw}, '0);
        chk({tag, "_strobes"}, {30'd0, reg_we, freg_we}, '0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
`ifdef WB_PENDING_EN
        chk({tag, "_pend"}, {20'd0, pend_valid, pend_is_f, pend_rd, pend_frd}, '0);
`endif
    endtask

    initial begin
        clearIn();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chkAllZero("reset");

        // ALU op to rd=7; strobe for one cycle, data holds afterwards.
        in_valid = 1; alu_out = 32'h1234; reg_wr = 1; rd = 7;
        push(1, 0, 32'h1234, '0, 7, '0);
        tick();
        chk("alu_reg_we", {31'd0, reg_we}, 32'd1);
        clearIn();
        tick();
        chk("alu_strobe_low", {31'd0, reg_we}, 32'd0);
        chk("alu_busW_hold", busW, 32'h1234);

        // JAL + move: link wins integer side, busA goes to FP side.
        in_valid = 1; mov_instr = 1; busW_ctrl = 1; jal_out = 32'h40; busA = 32'h5;
        fbusA = 32'h9; reg_wr = 1; freg_wr = 1; rd = 1; frd = 2;
        push(1, 1, 32'h40, 32'h5, 1, 2);
        tick();
        // Back-to-back: plain move (fbusA -> int), then FPU op with load select ignored by move.
        clearIn();
        in_valid = 1; mov_instr = 1; mem_to_reg = 1; fbusA = 32'hA5A5; reg_wr = 1; rd = 31;
        push(1, 0, 32'hA5A5, '0, 31, '0);
        tick();
        clearIn();
        in_valid = 1; fpu_out = 32'h3F80_0000; freg_wr = 1; frd = 0;
        push(0, 1, '0, 32'h3F80_0000, '0, 0);
        tick();
        clearIn();
        // mem_rvalid while idle is ignored.
        mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
        tick();
        chk("idle_rvalid_no_strobe", {30'd0, reg_we, freg_we}, '0);
        clearIn();

        // Load to rd=3, data three cycles after accept; ALU op waits behind it.
        in_valid = 1; mem_to_reg = 1; reg_wr = 1; rd = 3;
        push(1, 0, 32'hDEADBEEF, '0, 3, '0);
        tick();
        clearIn();
        in_valid = 1; alu_out = 32'h55; reg_wr = 1; rd = 9; jal_out = 32'h999;
        push(1, 0, 32'h55, '0, 9, '0);
        chk("ld_in_ready_c1", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ld_in_ready_c2", {31'd0, in_ready}, 32'd0);
        tick();
        chk("ld_in_ready_c3", {31'd0, in_ready}, 32'd0);
        chk("ld_no_early_strobe", {30'd0, reg_we, freg_we}, '0);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("ld_ret_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ld_ret_reg_we", {31'd0, reg_we}, 32'd1);
        mem_rvalid = 0;
        tick();
        chk("held_alu_retired", {31'd0, reg_we}, 32'd1);
        clearIn();

        // Load with JAL link latched, FP side takes load data, minimum latency.
        in_valid = 1; mem_to_reg = 1; busW_ctrl = 1; jal_out = 32'h77; reg_wr = 1;
        freg_wr = 1; rd = 4; frd = 5;
        push(1, 1, 32'h77, 32'hCAFEF00D, 4, 5);
        tick();
        clearIn();
        jal_out = 32'h1111; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        clearIn();
        tick();

        // flush and mem_rvalid together in WAIT_MEM: no strobe.
        in_valid = 1; mem_to_reg = 1; reg_wr = 1; rd = 6;
        tick();
        clearIn();
        flush = 1; mem_rvalid = 1; mem_rdata = 32'h0BAD;
        tick();
        chk("flush_no_strobe", {30'd0, reg_we, freg_we}, '0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        clearIn();
        // flush in IDLE does not block acceptance.
        in_valid = 1; flush = 1; alu_out = 32'h2468; reg_wr = 1; rd = 0;
        push(1, 0, 32'h2468, '0, 0, '0);
        tick();
        chk("idle_flush_accept", {31'd0, reg_we}, 32'd1);
        clearIn();

`ifdef WB_PENDING_EN
        // FP load to frd=12: pending outputs visible throughout the wait.
        in_valid = 1; mem_to_reg = 1; freg_wr = 1; frd = 12;
        push(0, 1, '0, 32'h4040_0000, '0, 12);
        tick();
        clearIn();
        for (int i = 0; i < 2; i++) begin
            chk("pend_valid", {31'd0, pend_valid}, 32'd1);
            chk("pend_frd", {27'd0, pend_frd}, 32'd12);
            chk("pend_is_f", {31'd0, pend_is_f}, 32'd1);
            if (i == 1) begin
                mem_rvalid = 1; mem_rdata = 32'h4040_0000;
            end
            tick();
        end
        chk("pend_clear", {31'd0, pend_valid}, 32'd0);
        chk("pend_freg_we", {31'd0, freg_we}, 32'd1);
        clearIn();
        tick();
`endif

        // Reset during WAIT_MEM drops the load.
        in_valid = 1; mem_to_reg = 1; reg_wr = 1; freg_wr = 1; rd = 8; frd = 8;
        tick();
        clearIn();
        #2 reset = 1'b1;
        #1 chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        reset = 1'b0;
        mem_rvalid = 1; mem_rdata = 32'h1357;
        tick();
        clearIn();
        tick();
        chkAllZero("reset_mid_wait");

        chk("sb_empty", sbQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_wb_stage
`default_nettype wire
